// File: rtl/press_classifier_if.sv
// Button gesture bus: conditioned edge pulses in, classified events and status out.
interface press_classifier_if;
  logic       rising;
  logic       falling;
  logic       short_press;
  logic       long_press;
  logic       double_press;
  logic       hold_active;
  logic       busy;
  logic [7:0] press_count;

  modport master (
    output rising, falling,
    input  short_press, long_press, double_press, hold_active, busy, press_count
  );

  modport slave (
    input  rising, falling,
    output short_press, long_press, double_press, hold_active, busy, press_count
  );
endinterface

// File: rtl/press_classifier.sv
// Classifies debounced button edge pulses into short, long and double press events.
module press_classifier #(
  parameter int unsigned LONG_T   = 16,
  parameter int unsigned DCLICK_T = 8,
  parameter int unsigned CW       = 8
) (
  input logic               clk,
  input logic               reset,
  press_classifier_if.slave btn
);

  typedef enum logic [2:0] {
    StIdle,
    StPressed,
    StLongHeld,
    StWaitSecond,
    StPressed2
  } state_e;

  localparam logic [CW-1:0] LongLast   = CW'(LONG_T - 1);
  localparam logic [CW-1:0] DclickLast = CW'(DCLICK_T - 1);
  localparam logic [CW-1:0] CntOne     = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    count_q, count_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          double_q, double_d;
  logic          hold_q, hold_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    count_d  = count_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;

    // Simultaneous edges carry no usable gesture information; freeze everything.
    if (!(btn.rising && btn.falling)) begin
      unique case (state_q)
        StIdle: begin
          if (btn.rising) begin
            state_d = StPressed;
            cnt_d   = '0;
            count_d = count_q + 8'd1;
          end
        end
        StPressed: begin
          if (btn.falling) begin
            state_d = StWaitSecond;
            cnt_d   = '0;
          end else if (cnt_q == LongLast) begin
            long_d  = 1'b1;
            state_d = StLongHeld;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StLongHeld: begin
          if (btn.falling) begin
            state_d = StIdle;
          end
        end
        StWaitSecond: begin
          if (btn.rising) begin
            state_d = StPressed2;
            cnt_d   = '0;
            count_d = count_q + 8'd1;
          end else if (cnt_q == DclickLast) begin
            short_d = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StPressed2: begin
          if (btn.falling) begin
            double_d = 1'b1;
            state_d  = StIdle;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d != StIdle);
    hold_d = (state_d == StLongHeld);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      count_q  <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      hold_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      hold_q   <= hold_d;
      busy_q   <= busy_d;
    end
  end

  assign btn.short_press  = short_q;
  assign btn.long_press   = long_q;
  assign btn.double_press = double_q;
  assign btn.hold_active  = hold_q;
  assign btn.busy         = busy_q;
  assign btn.press_count  = count_q;

endmodule
